// File: rtl/bridge_pkg.sv
// Shared types and constants for the peripheral bridge master and the bridge it drives.
package bridge_pkg;

  localparam int unsigned BRIDGE_AW = 32;
  localparam int unsigned BRIDGE_DW = 32;

  // Mapped peripheral slots on the bridge
  localparam int unsigned PERIPH0_ADDR = 0;
  localparam int unsigned PERIPH1_ADDR = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } bridge_state_e;

  typedef struct packed {
    logic                 write;
    logic [BRIDGE_AW-1:0] addr;
    logic [BRIDGE_DW-1:0] wdata;
  } bridge_req_t;

endpackage

// File: rtl/bridge_cmd_fifo.sv
// Command FIFO for the bridge master: power-of-2 ring buffer with a separate occupancy count.
module bridge_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the count gates every read of it
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (PtrW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/bridge_master.sv
// Sole master of the single-cycle peripheral bridge: queues requests, sequences IDLE/SETUP/ACCESS/RESP.
// Optional BRIDGE_MASTER_ADDR_CHECK_EN adds rsp_err and short-circuits unmapped addresses.
module bridge_master
  import bridge_pkg::*;
#(
  parameter int unsigned AW      = BRIDGE_AW,
  parameter int unsigned DW      = BRIDGE_DW,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned RD_WAIT = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_write,
  output logic [DW-1:0] rsp_rdata,
`ifdef BRIDGE_MASTER_ADDR_CHECK_EN
  output logic          rsp_err,
`endif
  output logic [AW-1:0] bus_address,
  output logic [DW-1:0] bus_in_data,
  output logic          bus_write,
  input  logic [DW-1:0] bus_out_data,
  output logic          busy
);

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  localparam int unsigned PW     = 1 + AW + DW;
  localparam logic [3:0]  RdWait = 4'(RD_WAIT);

  req_t          push_req, head;
  logic [PW-1:0] head_raw;
  logic          fifo_full, fifo_empty, push, pop;

  bridge_state_e state_q;
  logic          op_write_q;
  logic [3:0]    wait_q;
  logic [AW-1:0] bus_address_q;
  logic [DW-1:0] bus_in_data_q;
  logic          bus_write_q;
  logic          rsp_valid_q, rsp_write_q;
  logic [DW-1:0] rsp_rdata_q;

  assign push_req = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign head     = req_t'(head_raw);
  assign push     = req_valid && !fifo_full;
  assign pop      = (state_q == StIdle) && !fifo_empty;

  bridge_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PW)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .wdata_i (push_req),
    .pop_i   (pop),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef BRIDGE_MASTER_ADDR_CHECK_EN
  logic rsp_err_q;
  logic head_mapped;
  assign head_mapped = (head.addr == AW'(PERIPH0_ADDR)) || (head.addr == AW'(PERIPH1_ADDR));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      op_write_q    <= 1'b0;
      wait_q        <= '0;
      bus_address_q <= '0;
      bus_in_data_q <= '0;
      bus_write_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
`ifdef BRIDGE_MASTER_ADDR_CHECK_EN
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            op_write_q <= head.write;
`ifdef BRIDGE_MASTER_ADDR_CHECK_EN
            if (!head_mapped) begin
              rsp_valid_q <= 1'b1;
              rsp_write_q <= head.write;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
              state_q     <= StResp;
            end else
`endif
            begin
              // Bus is loaded at the pop so it is already valid throughout SETUP
              bus_address_q <= head.addr;
              bus_in_data_q <= head.wdata;
`ifdef BRIDGE_MASTER_ADDR_CHECK_EN
              rsp_err_q     <= 1'b0;
`endif
              state_q       <= StSetup;
            end
          end
        end
        StSetup: begin
          wait_q      <= op_write_q ? 4'd0 : RdWait;
          bus_write_q <= op_write_q;
          state_q     <= StAccess;
        end
        StAccess: begin
          if (op_write_q) begin
            bus_write_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= StResp;
          end else if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= bus_out_data;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready   = !fifo_full;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign bus_address = bus_address_q;
  assign bus_in_data = bus_in_data_q;
  assign bus_write   = bus_write_q;
  assign busy        = !fifo_empty || (state_q != StIdle);
`ifdef BRIDGE_MASTER_ADDR_CHECK_EN
  assign rsp_err     = rsp_err_q;
`endif

endmodule

// File: tb/tb_bridge_master.sv
// Scoreboard bench for bridge_master with a behavioural bridge (reg at 0, constant 0x539 at 4).
module tb_bridge_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [31:0] bus_address, bus_in_data, bus_out_data;
  logic        bus_write, busy;
`ifdef BRIDGE_MASTER_ADDR_CHECK_EN
  logic        rsp_err, d2_rsp_err;
`endif

  // Second instance only for RD_WAIT latency
  logic        d2_req_valid, d2_req_ready, d2_rsp_valid, d2_rsp_write, d2_bus_write, d2_busy;
  logic [31:0] d2_req_addr, d2_rsp_rdata, d2_bus_address, d2_bus_in_data, d2_bus_out_data;

  always #5 clk = ~clk;

  bridge_master #(.AW(32), .DW(32), .DEPTH(4), .RD_WAIT(0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
`ifdef BRIDGE_MASTER_ADDR_CHECK_EN
    .rsp_err      (rsp_err),
`endif
    .bus_address  (bus_address),
    .bus_in_data  (bus_in_data),
    .bus_write    (bus_write),
    .bus_out_data (bus_out_data),
    .busy         (busy)
  );

  bridge_master #(.AW(32), .DW(32), .DEPTH(4), .RD_WAIT(2)) dut2 (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (d2_req_valid),
    .req_ready    (d2_req_ready),
    .req_write    (1'b0),
    .req_addr     (d2_req_addr),
    .req_wdata    (32'h0),
    .rsp_valid    (d2_rsp_valid),
    .rsp_ready    (1'b1),
    .rsp_write    (d2_rsp_write),
    .rsp_rdata    (d2_rsp_rdata),
`ifdef BRIDGE_MASTER_ADDR_CHECK_EN
    .rsp_err      (d2_rsp_err),
`endif
    .bus_address  (d2_bus_address),
    .bus_in_data  (d2_bus_in_data),
    .bus_write    (d2_bus_write),
    .bus_out_data (d2_bus_out_data),
    .busy         (d2_busy)
  );

  // Bridge model: not reset by the master's reset
  logic [31:0] reg0 = 32'h0;
  assign bus_out_data    = (bus_address == 32'h0) ? reg0 :
                           (bus_address == 32'h4) ? 32'h539 : 32'h0;
  assign d2_bus_out_data = (d2_bus_address == 32'h4) ? 32'h539 : 32'h0;
  always @(posedge clk) if (bus_write && bus_address == 32'h0) reg0 <= bus_in_data;

  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model_reg0 = 32'h0;
  int          errors = 0;
  int          checks = 0;
  int          wr_pulses = 0;
  logic        prev_bw = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_write", {31'd0, rsp_write}, {31'd0, mon_e.write});
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
`ifdef BRIDGE_MASTER_ADDR_CHECK_EN
        check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && bus_write) begin
      wr_pulses++;
      if (prev_bw) check("bus_write_len", 32'd1, 32'd0);
    end
    prev_bw = reset_n && bus_write;
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("req_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      e.write = w;
`ifdef BRIDGE_MASTER_ADDR_CHECK_EN
      e.err = !(a == 32'h0 || a == 32'h4);
`else
      e.err = 1'b0;
`endif
      e.rdata = (w || e.err) ? 32'h0 : (a == 32'h0) ? model_reg0 : (a == 32'h4) ? 32'h539 : 32'h0;
      if (w && !e.err && a == 32'h0) model_reg0 = d;
      exp_q.push_back(e);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          cyc, n, pulses;
    logic [31:0] prev_addr, prev_data, saved;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; d2_req_valid = 1'b0; d2_req_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_bus_write", {31'd0, bus_write}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bus_address", bus_address, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    reset_n = 1'b1;

    // Write then read address 0, checking the write pulse and SETUP-stable bus
    send(1'b1, 32'h0, 32'hDEADBEEF);
    prev_addr = 32'hFFFFFFFF; prev_data = 32'h0; n = 0;
    @(negedge clk);
    while (!bus_write && n < 20) begin
      prev_addr = bus_address; prev_data = bus_in_data;
      @(negedge clk);
      n++;
    end
    check("wr_pulse_seen", {31'd0, bus_write}, 32'd1);
    check("setup_addr", prev_addr, 32'h0);
    check("setup_data", prev_data, 32'hDEADBEEF);
    check("access_addr", bus_address, 32'h0);
    check("access_data", bus_in_data, 32'hDEADBEEF);
    @(negedge clk);
    check("wr_pulse_end", {31'd0, bus_write}, 32'd0);
    send(1'b0, 32'h0, 32'h0);
    wait_idle();
    check("wr_pulse_count", wr_pulses, 32'd1);

    // Minimum read latency, RD_WAIT=0
    pulses = wr_pulses;
    send(1'b0, 32'h4, 32'h0);
    cyc = 1;
    @(negedge clk);
    while (!rsp_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("lat_rdwait0", cyc, 32'd4);
    wait_idle();
    check("rd_no_bus_write", wr_pulses, pulses);

    // RD_WAIT=2 instance
    @(posedge clk); #1;
    d2_req_valid = 1'b1; d2_req_addr = 32'h4;
    @(posedge clk); #1;
    d2_req_valid = 1'b0;
    cyc = 1;
    @(negedge clk);
    while (!d2_rsp_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("lat_rdwait2", cyc, 32'd6);
    check("d2_rdata", d2_rsp_rdata, 32'h539);
    check("d2_write", {31'd0, d2_rsp_write}, 32'd0);

    // Stall in RESP while the FIFO fills
    rsp_ready = 1'b0;
    send(1'b1, 32'h0, 32'h11111111);
    send(1'b0, 32'h0, 32'h0);
    send(1'b0, 32'h4, 32'h0);
    send(1'b1, 32'h0, 32'h22222222);
    send(1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("full_req_ready", {31'd0, req_ready}, 32'd0);
    check("full_busy", {31'd0, busy}, 32'd1);
    pulses = wr_pulses;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_write", {31'd0, rsp_write}, {31'd0, exp_q[0].write});
      check("stall_rdata", rsp_rdata, exp_q[0].rdata);
    end
    check("stall_no_bus_write", wr_pulses, pulses);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_release", {31'd0, rsp_valid}, 32'd0);
    wait_idle();
    check("stall_drained", exp_q.size(), 32'd0);

    // Reset during the ACCESS cycle of a write
    saved = model_reg0;
    send(1'b1, 32'h0, 32'hBADC0DE0);
    n = 0;
    @(negedge clk);
    while (!bus_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_wr_seen", {31'd0, bus_write}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_bus_write", {31'd0, bus_write}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    model_reg0 = saved;
    @(negedge clk);
    reset_n = 1'b1;
    send(1'b0, 32'h0, 32'h0);
    wait_idle();
    check("reg0_after_rst", reg0, 32'h22222222);

    // Unmapped read, then mapped read
    pulses = wr_pulses;
    send(1'b0, 32'h8, 32'h0);
    wait_idle();
    check("unmapped_no_write", wr_pulses, pulses);
`ifdef BRIDGE_MASTER_ADDR_CHECK_EN
    check("unmapped_bus_addr", bus_address, 32'h0);
`else
    check("unmapped_bus_addr", bus_address, 32'h8);
`endif
    send(1'b0, 32'h4, 32'h0);
    wait_idle();
    check("final_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
